msg_uart_tx: RTL

MSG_UART_TX -- requirements
Module: msg_uart_tx

---
 rtl/msg_uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/msg_uart_tx.sv
// Serial transmitter for a four-character message: sends msg as 8N1 bytes,
// leftmost character first, optionally followed by CR LF.
module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADD_CRLF     = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] msg,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int          NBYTES    = (ADD_CRLF != 0) ? 6 : 4;
  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t      state, state_d;
  logic [15:0] timer, timer_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [2:0]  byte_idx, byte_idx_d;
  logic [31:0] msg_q, msg_d;
  logic        tx_d, busy_d, done_d;

  logic [7:0]  cur_byte;
  logic [2:0]  bit_next;
  logic        bit_end;

  // Byte being framed; positions 4 and 5 only occur when CR LF is appended.
  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = msg_q[31:24];
      3'd1:    cur_byte = msg_q[23:16];
      3'd2:    cur_byte = msg_q[15:8];
      3'd3:    cur_byte = msg_q[7:0];
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_next = bit_idx + 3'd1;
  assign bit_end  = (timer == LAST_TICK);

  // Next-state logic. tx_d is the level for the cycle that follows the edge,
  // so tx itself comes straight from a flop.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_d    = state;
    timer_d    = timer;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    msg_d      = msg_q;
    tx_d       = tx;
    busy_d     = busy;
    done_d     = 1'b0;

    unique case (state)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = START_BIT;
          timer_d    = '0;
          byte_idx_d = '0;
          msg_d      = msg;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          state_d   = DATA_BITS;
          timer_d   = '0;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end else begin
          timer_d = timer + 16'd1;
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_next;
            tx_d      = cur_byte[bit_next];
          end
        end else begin
          timer_d = timer + 16'd1;
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_idx == LAST_BYTE) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_d    = START_BIT;
            byte_idx_d = byte_idx + 3'd1;
            tx_d       = 1'b0;
          end
        end else begin
          timer_d = timer + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      msg_q    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_d;
      timer    <= timer_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      msg_q    <= msg_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
